// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with a per-register busy scoreboard for RAW stalls.
// Define RF_BYPASS_EN to forward same-cycle writeback data and busy state to the read ports.
module regfile_sb #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned REG_COUNT  = 32,
   parameter int unsigned NUM_RD     = 3,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
   output logic [NUM_RD-1:0]              rd_busy,
   input  logic                           wb0_en,
   input  logic [ADDR_WIDTH-1:0]          wb0_addr,
   input  logic [DATA_WIDTH-1:0]          wb0_data,
   input  logic                           wb1_en,
   input  logic [ADDR_WIDTH-1:0]          wb1_addr,
   input  logic [DATA_WIDTH-1:0]          wb1_data,
   input  logic                           iss_en,
   input  logic [ADDR_WIDTH-1:0]          iss_addr,
   output logic                           wb_err,
   output logic [ADDR_WIDTH:0]            busy_cnt
);

   localparam int unsigned IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam int unsigned CW = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [REG_COUNT-1:0]  busy_q, busy_d;
   logic                  wb_err_q, wb_err_d;
   logic [CW-1:0]         busy_cnt_q, busy_cnt_d;

   logic wb0_ok, wb1_ok, iss_ok;

   // True for addresses that map to real, writable state.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) < REG_COUNT) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
      return a[IW-1:0];
   endfunction

   assign wb0_ok = wb0_en && addr_ok(wb0_addr);
   assign wb1_ok = wb1_en && addr_ok(wb1_addr);
   assign iss_ok = iss_en && addr_ok(iss_addr);

   // Issue is applied after the clears so a new producer keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (wb0_ok) busy_d[idx(wb0_addr)] = 1'b0;
      if (wb1_ok) busy_d[idx(wb1_addr)] = 1'b0;
      if (iss_ok) busy_d[idx(iss_addr)] = 1'b1;
   end

   always_comb begin
      wb_err_d = 1'b0;
      if (wb0_ok && !busy_q[idx(wb0_addr)]) wb_err_d = 1'b1;
      if (wb1_ok && !busy_q[idx(wb1_addr)]) wb_err_d = 1'b1;
   end

   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < int'(REG_COUNT); i++) begin
         busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(REG_COUNT); i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         wb_err_q   <= 1'b0;
         busy_cnt_q <= '0;
      end else begin
         // wb1 is written last so it wins on an address collision.
         if (wb0_ok) regs_q[idx(wb0_addr)] <= wb0_data;
         if (wb1_ok) regs_q[idx(wb1_addr)] <= wb1_data;
         busy_q     <= busy_d;
         wb_err_q   <= wb_err_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < int'(NUM_RD); k++) begin
         logic [ADDR_WIDTH-1:0] a;
         a = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         if (addr_ok(a)) begin
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[idx(a)];
            rd_busy[k]                          = busy_q[idx(a)];
`ifdef RF_BYPASS_EN
            if (wb1_ok && (wb1_addr == a)) begin
               rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wb1_data;
               rd_busy[k]                          = iss_ok && (iss_addr == a);
            end else if (wb0_ok && (wb0_addr == a)) begin
               rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wb0_data;
               rd_busy[k]                          = iss_ok && (iss_addr == a);
            end
`endif
         end
      end
   end

   assign wb_err   = wb_err_q;
   assign busy_cnt = busy_cnt_q;

endmodule
